// File: rtl/md_pkg.sv
// md_pkg: op encodings, FSM states and helpers for the mult/div scheduler
// MD_MADD_EN: when defined, madd/msub (ops 110/111) occupy the unit; otherwise they are ignored.
package md_pkg;
  localparam int CNT_W = 4;
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MADD  = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  function automatic logic uses_unit(input logic [2:0] op);
`ifdef MD_MADD_EN
    return op[2:1] != 2'b10;
`else
    return !op[2];
`endif
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/md_alu.sv
// md_alu: combinational mult/div/accumulate result for the HI/LO pair
// Ports: op, a, b, hi, lo in; res = {hi,lo} candidate, we = 0 on divide by zero.
module md_alu
  import md_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   hi,
  input  logic [W-1:0]   lo,
  output logic [2*W-1:0] res,
  output logic           we
);
  logic [2*W-1:0] ps, pu, acc;
  logic [W-1:0] ma, mb, mq, mr, q, r, uq, ur;
  logic sa, sb, bz;
  // Signed divide works on magnitudes so MIN/-1 wraps to MIN with remainder 0.
  always_comb begin
    ps = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    pu = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    acc = {hi, lo};
    bz = b == '0;
    sa = a[W-1];
    sb = b[W-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    mq = bz ? '0 : ma / mb;
    mr = bz ? '0 : ma % mb;
    q = (sa ^ sb) ? -mq : mq;
    r = sa ? -mr : mr;
    uq = bz ? '0 : a / b;
    ur = bz ? '0 : a % b;
    res = op == MD_MULTU ? pu :
          op == MD_DIV   ? {r, q} :
          op == MD_DIVU  ? {ur, uq} :
          op == MD_MADD  ? acc + ps :
          op == MD_MSUB  ? acc - ps : ps;
    we = !(is_div(op) && bz);
  end
endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle mult/div sequencing, HI/LO ownership and ID hazard stall
// Ports: clk, reset (async high), start/op/a/b from EX, id_md_use from ID;
// busy, stall, hi, lo out. MD_MADD_EN enables madd/msub.
module md_scheduler
  import md_pkg::*;
#(
  parameter int W = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         id_md_use,
  output logic         busy,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0] pend, res;
  logic pend_we, we, take, last;
  md_alu #(.W(W)) u_alu (.op(op), .a(a), .b(b), .hi(hi), .lo(lo), .res(res), .we(we));
  always_comb begin
    busy = state == S_RUN;
    last = busy && cnt == CNT_W'(1);
    take = start && !busy && uses_unit(op);
    stall = id_md_use && (busy || (start && uses_unit(op)));
    state_nx = take ? S_RUN : last ? S_IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  // Result is captured at issue; the stall keeps HI/LO frozen until commit.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      pend <= '0;
      pend_we <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (take) begin
      cnt <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend <= res;
      pend_we <= we;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (last && pend_we) {hi, lo} <= pend;
    end else if (start && op == MD_MTHI) hi <= a;
    else if (start && op == MD_MTLO) lo <= a;
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed scoreboard bench for md_scheduler
module tb_md_scheduler;
  import md_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, id_md_use = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic busy, stall;
  logic [31:0] hi, lo;
  md_scheduler #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .id_md_use(id_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    string name;
    logic [31:0] hi, lo;
    logic busy, stall, chk_stall;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, total = 0, passed = 0;
  logic [31:0] ehi = 32'd0, elo = 32'd0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset && start && busy) begin
      total++;
      $display("FAIL start_while_busy @%0d: start=%b busy=%b, required start=0 while busy", cyc, start, busy);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc == cyc && hi === e.hi && lo === e.lo && busy === e.busy && (!e.chk_stall || stall === e.stall))
        passed++;
      else
        $display("FAIL %s @%0d (now %0d): hi=%h lo=%h busy=%b stall=%b, required hi=%h lo=%h busy=%b stall=%b",
                 e.name, e.cyc, cyc, hi, lo, busy, stall, e.hi, e.lo, e.busy, e.stall);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_at(input string n, input logic [31:0] h, input logic [31:0] l,
                           input logic bz, input logic st, input logic cs);
    q.push_back('{cyc, n, h, l, bz, st, cs});
  endtask
  task automatic issue(input string n, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int lat, input logic u, input logic [31:0] nh, input logic [31:0] nl);
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    id_md_use = u;
    expect_at({n, "_t0"}, ehi, elo, 1'b0, u && lat > 0, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      start = 1'b0;
      expect_at({n, "_busy"}, ehi, elo, 1'b1, u, 1'b1);
    end
    tick();
    start = 1'b0;
    expect_at({n, "_done"}, nh, nl, 1'b0, 1'b0, 1'b1);
    ehi = nh;
    elo = nl;
    tick();
    id_md_use = 1'b0;
  endtask
  task automatic mtpair(input string n, input logic [31:0] hv, input logic [31:0] lv);
    start = 1'b1;
    op = MD_MTHI;
    a = hv;
    expect_at({n, "_mthi_t0"}, ehi, elo, 1'b0, 1'b0, 1'b1);
    tick();
    op = MD_MTLO;
    a = lv;
    expect_at({n, "_mthi_lands"}, hv, elo, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    expect_at({n, "_mtlo_lands"}, hv, lv, 1'b0, 1'b0, 1'b1);
    ehi = hv;
    elo = lv;
    tick();
  endtask
  initial begin
    tick();
    tick();
    id_md_use = 1'b1;
    expect_at("reset_state", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    id_md_use = 1'b0;
    tick();
    mtpair("mt", 32'hDEADBEEF, 32'h12345678);
    start = 1'b1;
    op = MD_MULT;
    a = 32'd3;
    b = 32'd4;
    expect_at("rst_run_t0", ehi, elo, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    expect_at("rst_run_busy", ehi, elo, 1'b1, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    expect_at("rst_async", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    ehi = 32'd0;
    elo = 32'd0;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    expect_at("rst_no_commit", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    issue("mult_stall", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue("mult_nostall", MD_MULT, 32'd2, 32'd5, 5, 1'b0, 32'd0, 32'd10);
`ifdef MD_MADD_EN
    issue("madd", MD_MADD, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'd0, 32'd4);
`else
    issue("madd_off", MD_MADD, 32'hFFFFFFFE, 32'd3, 0, 1'b1, 32'd0, 32'd10);
`endif
    issue("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 32'd1, 32'hFFFFFFFE);
    issue("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mtpair("set11", 32'h11, 32'h11);
    issue("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 1'b0, 32'h11, 32'h11);
    issue("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd0, 32'h80000000);
`ifdef MD_MADD_EN
    issue("msub", MD_MSUB, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'd0, 32'h80000006);
`else
    issue("msub_off", MD_MSUB, 32'hFFFFFFFE, 32'd3, 0, 1'b1, 32'd0, 32'h80000000);
`endif
    for (int k = 0; k < 50 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
